// File: rtl/fifo_pkg.sv
// Shared constants for the store-buffer FIFO drain path.
package fifo_pkg;

    localparam int FIFO_READER_SLOTS     = 2;
    localparam int FIFO_READER_BURST_LEN = 16;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-slot output register buffer: tail write, head pop, occupancy count.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] slot [FIFO_READER_SLOTS];
    logic                  hd;
    logic                  tl;

    // Tail sits on the head slot when empty, on the other slot when one word is held.
    assign tl        = hd ^ count[0];
    assign head_data = slot[hd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_READER_SLOTS; i++) begin
                slot[i] <= '0;
            end
            hd    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (wr_en) begin
                slot[tl] <= wr_data;
            end
            if (pop) begin
                hd <= ~hd;
            end
            count <= count + 2'(wr_en) - 2'(pop);
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// FIFO drain engine: issues reads, absorbs RAM latency, drives a valid/ready stream.
// Define FIFO_READER_BURST_EN to build the beat counter that drives m_last_o.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = FIFO_READER_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o
);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_reader: DATA_WIDTH must be at least 1");
    end
    if ((BURST_LEN < 2) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_burst
        $error("fifo_reader: BURST_LEN must be a power of two >= 2");
    end

    logic       inflight;
    logic       pop;
    logic [1:0] count;
    logic [2:0] level;

    assign pop       = m_valid_o & m_ready_i;
    assign m_valid_o = (count != 2'd0);

    // Projected occupancy after this edge; a read is only safe if a slot stays free for it.
    assign level        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en_o = !rst && !fifo_empty_i && (level < 3'(FIFO_READER_SLOTS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en_o;
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (inflight),
        .wr_data   (fifo_rd_data_i),
        .pop       (pop),
        .head_data (m_data_o),
        .count     (count)
    );

`ifdef FIFO_READER_BURST_EN
    localparam int BEAT_W = $clog2(BURST_LEN);

    logic [BEAT_W-1:0] beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (pop) begin
            beat <= beat + BEAT_W'(1);
        end
    end

    assign m_last_o = m_valid_o && (beat == BEAT_W'(BURST_LEN - 1));
`else
    assign m_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural single-clock FIFO on its read side.
module tb_fifo_reader;

    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_rd_data_i;
    logic          fifo_empty_i;
    logic          fifo_rd_en_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic          m_last_o;

    int tests = 0;
    int fails = 0;

    fifo_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_last_o       (m_last_o)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: one-cycle read latency, pointers cleared by rst.
    logic [DW-1:0] fmem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty_i = (wr_ptr == rd_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr         <= 0;
            fifo_rd_data_i <= '0;
        end else if (fifo_rd_en_o) begin
            fifo_rd_data_i <= fmem[rd_ptr % 64];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream monitor sampled on the falling edge, ahead of the edge that acts on it.
    int            n_reads = 0;
    int            n_pops  = 0;
    int            tb_beat = 0;
    logic          exp_last;
    logic [DW-1:0] rx_data [$];
    logic          rx_last [$];

    always @(negedge clk) begin
        if (rst) begin
            n_reads = 0;
            n_pops  = 0;
            tb_beat = 0;
        end else begin
`ifdef FIFO_READER_BURST_EN
            exp_last = m_valid_o && (tb_beat == BL - 1);
`else
            exp_last = 1'b0;
`endif
            check("m_last", 32'(m_last_o), 32'(exp_last));
            if (fifo_rd_en_o && fifo_empty_i) begin
                check("overread", 32'(fifo_rd_en_o & fifo_empty_i), 32'd0);
            end
            if (fifo_rd_en_o) n_reads++;
            if (m_valid_o && m_ready_i) begin
                n_pops++;
                rx_data.push_back(m_data_o);
                rx_last.push_back(m_last_o);
                tb_beat = (tb_beat + 1) % BL;
            end
            check("occupancy_le_2", 32'(n_reads - n_pops <= 2), 32'd1);
        end
    end

    task automatic push_word(input logic [DW-1:0] v);
        fmem[wr_ptr % 64] = v;
        wr_ptr++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        wr_ptr    = 0;
        m_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rx_data.delete();
        rx_last.delete();
    endtask

    typedef struct {
        logic          ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_rd_en;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Back-to-back stream of 8 pre-loaded words, consumer always ready.
        vecs[0]  = '{1'b1, 1'b0, 32'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 32'h01, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 32'h02, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 32'h03, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 32'h04, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 32'h05, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h06, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 32'h07, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h08, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b0};

        #2;
        check("reset_valid", 32'(m_valid_o), 32'd0);
        check("reset_rd_en", 32'(fifo_rd_en_o), 32'd0);
        check("reset_last", 32'(m_last_o), 32'd0);
        check("reset_data", m_data_o, 32'h0);

        do_reset();
        m_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        for (int i = 0; i < 11; i++) begin
            m_ready_i = vecs[i].ready;
            @(negedge clk);
            check($sformatf("b2b_valid[%0d]", i), 32'(m_valid_o), 32'(vecs[i].exp_valid));
            check($sformatf("b2b_rd_en[%0d]", i), 32'(fifo_rd_en_o), 32'(vecs[i].exp_rd_en));
            if (vecs[i].exp_valid) begin
                check($sformatf("b2b_data[%0d]", i), m_data_o, vecs[i].exp_data);
            end
            next_cycle();
        end
        check("b2b_count", 32'(rx_data.size()), 32'd8);
        for (int i = 0; i < rx_data.size() && i < 8; i++) begin
            check($sformatf("b2b_order[%0d]", i), rx_data[i], DW'(i + 1));
        end

        // Backpressure: 5 words queued, consumer stalled.
        do_reset();
        for (int i = 1; i <= 5; i++) push_word(DW'(i));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check($sformatf("bp_hold_valid[%0d]", c), 32'(m_valid_o), 32'd1);
                check($sformatf("bp_hold_data[%0d]", c), m_data_o, 32'h01);
            end
            next_cycle();
        end
        check("bp_reads", 32'(n_reads), 32'd2);
        m_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_nogap[%0d]", c), 32'(m_valid_o), 32'd1);
            next_cycle();
        end
        @(negedge clk);
        check("bp_drained", 32'(m_valid_o), 32'd0);
        check("bp_count", 32'(rx_data.size()), 32'd5);
        for (int i = 0; i < rx_data.size() && i < 5; i++) begin
            check($sformatf("bp_order[%0d]", i), rx_data[i], DW'(i + 1));
        end
        next_cycle();

        // Single word, empty flag toggling.
        do_reset();
        m_ready_i = 1'b1;
        push_word(32'hA5);
        repeat (6) next_cycle();
        check("single_reads", 32'(n_reads), 32'd1);
        check("single_beats", 32'(rx_data.size()), 32'd1);
        if (rx_data.size() > 0) check("single_data", rx_data[0], 32'hA5);
        push_word(32'h5A);
        repeat (6) next_cycle();
        check("single2_reads", 32'(n_reads), 32'd2);
        check("single2_beats", 32'(rx_data.size()), 32'd2);
        if (rx_data.size() > 1) check("single2_data", rx_data[1], 32'h5A);

        // Alternating ready over 10 words.
        do_reset();
        for (int i = 0; i < 10; i++) push_word(DW'(32'h10 + i));
        for (int c = 0; c < 60; c++) begin
            m_ready_i = (c % 2 == 0);
            next_cycle();
        end
        check("alt_count", 32'(rx_data.size()), 32'd10);
        for (int i = 0; i < rx_data.size() && i < 10; i++) begin
            check($sformatf("alt_order[%0d]", i), rx_data[i], DW'(32'h10 + i));
        end

        // Asynchronous reset mid-cycle with a read in flight and a word buffered.
        do_reset();
        m_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) push_word(DW'(32'h40 + i));
        repeat (3) next_cycle();
        @(negedge clk);
        check("pre_rst_valid", 32'(m_valid_o), 32'd1);
        check("pre_rst_rd_en", 32'(fifo_rd_en_o), 32'd1);
        #2;
        rst    = 1'b1;
        wr_ptr = 0;
        #1;
        check("async_rst_valid", 32'(m_valid_o), 32'd0);
        check("async_rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
        check("async_rst_data", m_data_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rx_data.delete();
        rx_last.delete();
        m_ready_i = 1'b1;
        push_word(32'h77);
        repeat (6) next_cycle();
        check("post_rst_count", 32'(rx_data.size()), 32'd1);
        if (rx_data.size() > 0) check("post_rst_first", rx_data[0], 32'h77);

`ifdef FIFO_READER_BURST_EN
        // Burst marking with BURST_LEN = 4 over 9 words.
        do_reset();
        m_ready_i = 1'b1;
        for (int i = 1; i <= 9; i++) push_word(DW'(i));
        repeat (14) next_cycle();
        check("burst_count", 32'(rx_data.size()), 32'd9);
        for (int i = 0; i < rx_last.size() && i < 9; i++) begin
            check($sformatf("burst_last[%0d]", i + 1), 32'(rx_last[i]), 32'((i == 3) || (i == 7)));
        end
        check("burst_beat_end", 32'(tb_beat), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
